// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract: one nibble per clock through a single
// 4-bit carry-lookahead slice, with carry/overflow/zero flags and start/done handshake.
module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       dbg_state
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic              carry_q, carry_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [3:0] slice_x, slice_y, slice_p, slice_g, slice_s;
    logic [4:0] slice_c;

    // 4-bit carry-lookahead slice on the currently selected nibble.
    always_comb begin
        slice_x = opa_q[{idx_q, 2'b00} +: 4];
        slice_y = opb_q[{idx_q, 2'b00} +: 4];
        slice_p = slice_x ^ slice_y;
        slice_g = slice_x & slice_y;
        slice_c[0] = carry_q;
        slice_c[1] = slice_g[0] | (slice_p[0] & carry_q);
        slice_c[2] = slice_g[1] | (slice_p[1] & slice_g[0])
                   | (slice_p[1] & slice_p[0] & carry_q);
        slice_c[3] = slice_g[2] | (slice_p[2] & slice_g[1])
                   | (slice_p[2] & slice_p[1] & slice_g[0])
                   | (slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
        slice_c[4] = slice_g[3] | (slice_p[3] & slice_g[2])
                   | (slice_p[3] & slice_p[2] & slice_g[1])
                   | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
                   | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
        slice_s = slice_p ^ slice_c[3:0];
    end

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtract is a + ~b + 1: invert B and seed the carry with 1.
                    opa_d    = a;
                    opb_d    = sub ? ~b : b;
                    carry_d  = sub;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = slice_s;
                carry_d = slice_c[4];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                    cout_d  = slice_c[4];
                    ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                              (slice_s[3] != opa_q[WIDTH-1]);
                    zero_d  = (result_d == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Handshake: busy while RUN, done for the single DONE cycle; never both.
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: vector table of add/sub cases plus hand-written
// handshake and reset sequences, all at WIDTH=32 (8-cycle latency).
module tb_nibble_serial_adder;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, overflow, zero;
    logic [W-1:0] result;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout),
        .overflow(overflow), .zero(zero), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] eres;
        logic         ecout;
        logic         eovf;
        logic         ezero;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic accept(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vsub);
        a = va; b = vb; sub = vsub; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the accepting edge. poke >= 0 pulses start with junk operands
    // in that RUN cycle; operands are scrambled every cycle regardless.
    task automatic wait_check(input string nm, input logic [W-1:0] eres, input logic ec,
                              input logic ev, input logic ez, input int poke);
        int bad;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (!(busy === 1'b1 && done === 1'b0)) bad++;
            start = (i == poke);
            a = $urandom;
            b = $urandom;
            sub = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        chk({nm, "_busy_window"}, W'(bad), '0);
        chk({nm, "_done"}, W'(done), W'(1));
        chk({nm, "_busy_at_done"}, W'(busy), '0);
        chk({nm, "_result"}, result, eres);
        chk({nm, "_cout"}, W'(cout), W'(ec));
        chk({nm, "_overflow"}, W'(overflow), W'(ev));
        chk({nm, "_zero"}, W'(zero), W'(ez));
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_busy"}, W'(busy), '0);
        chk({nm, "_done"}, W'(done), '0);
        chk({nm, "_result"}, result, '0);
        chk({nm, "_flags"}, W'({cout, overflow, zero}), '0);
        chk({nm, "_state"}, W'(dbg_state), '0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{32'h4000_0000, 32'hC000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};

        // Reset values
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_all_zero("reset");
        tick();
        tick();
        chk("idle_busy", W'(busy), '0);
        chk("idle_done", W'(done), '0);

        // Vector table, each followed by a DONE -> IDLE cycle with held outputs
        for (int v = 0; v < 10; v++) begin
            accept(vecs[v].va, vecs[v].vb, vecs[v].vsub);
            wait_check($sformatf("vec%0d", v), vecs[v].eres, vecs[v].ecout,
                       vecs[v].eovf, vecs[v].ezero, -1);
            tick();
            chk($sformatf("vec%0d_done_pulse", v), W'(done), '0);
            chk($sformatf("vec%0d_hold", v), result, vecs[v].eres);
        end

        // start pulsed 3 cycles into a run is ignored; back-to-back start in DONE
        accept(32'h0000_0100, 32'h0000_0200, 1'b0);
        wait_check("ignore_start", 32'h0000_0300, 1'b0, 1'b0, 1'b0, 3);
        accept(32'h0000_0010, 32'h0000_0020, 1'b0);
        wait_check("back_to_back", 32'h0000_0030, 1'b0, 1'b0, 1'b0, -1);
        tick();
        chk("b2b_idle_state", W'(dbg_state), '0);

        // Reset during RUN cycle 4 aborts with no done
        accept(32'h0000_0003, 32'h0000_0004, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("midrun_reset");
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                if (done === 1'b1 || busy === 1'b1) seen++;
                tick();
            end
            chk("midrun_no_done", W'(seen), '0);
        end
        accept(32'h0000_0001, 32'h0000_0001, 1'b0);
        wait_check("after_reset", 32'h0000_0002, 1'b0, 1'b0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
